// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// funct3 encodings, FSM states and the funct3 legality check.
package lsu_pkg;

  localparam int DW = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  // Stores have no unsigned forms, so only B/H/W are legal for them.
  function automatic logic f3_legal(
    input logic [2:0] f3,
    input logic       st
  );
    if (st)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B)  || (f3 == F3_H) ||
           (f3 == F3_W)  || (f3 == F3_BU) ||
           (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Handshake bundles of the load/store unit: the EX-side request
// channel and the data-memory request/grant/response port.
interface lsu_ex_if;
  import lsu_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          MemRead;
  logic          MemWrite;
  logic [2:0]    Funct3;
  logic [DW-1:0] ALUResult;
  logic [DW-1:0] WrData;
  logic          rsp_valid;
  logic          fault;
  logic [DW-1:0] RdData;

  modport master (
    output req_valid, MemRead, MemWrite,
    output Funct3, ALUResult, WrData,
    input  req_ready, rsp_valid, fault, RdData
  );

  modport slave (
    input  req_valid, MemRead, MemWrite,
    input  Funct3, ALUResult, WrData,
    output req_ready, rsp_valid, fault, RdData
  );
endinterface

interface lsu_mem_if;
  import lsu_pkg::*;

  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_mem_align.sv
// Byte-lane steering: store enables/replication, load extraction
// with sign/zero extension, and the natural-alignment check.
module mem_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misal_o
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata_i[{off_i, 3'b000} +: 8];
  assign h = rdata_i[{off_i[1], 4'b0000} +: 16];

  // Decode access size into lanes, extension and alignment.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    misal_o = 1'b0;
    unique case (1'b1)
      (f3_i == F3_B) || (f3_i == F3_BU): begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (f3_i == F3_B) ?
                  {{24{b[7]}}, b} : {24'b0, b};
      end
      (f3_i == F3_H) || (f3_i == F3_HU): begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (f3_i == F3_H) ?
                  {{16{h[15]}}, h} : {16'b0, h};
        misal_o = off_i[0];
      end
      (f3_i == F3_W): begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        misal_o = (off_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one EX memory op, runs the
// req/gnt/rvalid transaction and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  lsu_ex_if.slave   ex,
  lsu_mem_if.master mem
);

  lsu_state_t state_q;

  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] rd_q;

  logic        idle;
  logic        accept;
  logic        fault_d;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misal;

  assign idle   = (state_q == IDLE);
  assign accept = idle & ex.req_valid &
                  (ex.MemRead | ex.MemWrite);

  // In IDLE the aligner looks at the incoming op; afterwards it
  // works from the captured funct3/offset for load extraction.
  assign al_f3  = idle ? ex.Funct3 : f3_q;
  assign al_off = idle ? ex.ALUResult[1:0] : off_q;

  assign fault_d = (ex.MemRead & ex.MemWrite) |
                   ~f3_legal(ex.Funct3, ex.MemWrite) |
                   al_misal;

  mem_align u_align (
    .f3_i    (al_f3),
    .off_i   (al_off),
    .wdata_i (ex.WrData),
    .rdata_i (mem.mem_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata),
    .misal_o (al_misal)
  );

  assign ex.req_ready  = idle;
  assign ex.rsp_valid  = rsp_q;
  assign ex.fault      = fault_q;
  assign ex.RdData     = rd_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rsp_q     <= 1'b0;
      fault_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      rsp_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            f3_q  <= ex.Funct3;
            off_q <= ex.ALUResult[1:0];
            if (fault_d) begin
              state_q <= RESP;
              rsp_q   <= 1'b1;
              fault_q <= 1'b1;
              rd_q    <= '0;
            end else begin
              state_q   <= REQ;
              mem_req_q <= 1'b1;
              mem_we_q  <= ex.MemWrite;
              addr_q    <= {ex.ALUResult[31:2], 2'b00};
              be_q      <= al_be;
              wdata_q   <= ex.MemWrite ? al_wdata : '0;
            end
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state_q <= RESP;
              rsp_q   <= 1'b1;
              rd_q    <= '0;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            state_q <= RESP;
            rsp_q   <= 1'b1;
            rd_q    <= al_rdata;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus
// random ops compared against a behavioural lane/extension model.
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  lsu_ex_if  ex_bus ();
  lsu_mem_if mem_bus ();

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .ex    (ex_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: size from funct3, natural alignment by modulo,
  // lanes by multiplication, extension by masking.
  function automatic void model(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rw,
    output logic        f,
    output logic [3:0]  be,
    output logic [31:0] wdo,
    output logic [31:0] rdo
  );
    int          sz;
    int          off;
    bit          legal;
    logic [31:0] mask;
    logic [31:0] v;
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wr ? (f3 < 3'd3) : (f3 != 3'd3 && f3 < 3'd6);
    off   = int'(a[1:0]);
    f     = (rd && wr) || !legal || ((off % sz) != 0);
    mask  = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
    be    = 4'(((1 << sz) - 1) << off);
    wdo   = (wd & mask) * ((sz == 1) ? 32'h0101_0101 :
                           (sz == 2) ? 32'h0001_0001 : 32'h1);
    v = (rw >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    rdo = (f || wr) ? 32'h0 : v;
  endfunction

  task automatic idle_bus();
    ex_bus.req_valid    = 1'b0;
    ex_bus.MemRead      = 1'b0;
    ex_bus.MemWrite     = 1'b0;
    mem_bus.mem_gnt     = 1'b0;
    mem_bus.mem_rvalid  = 1'b0;
  endtask

  task automatic do_op(
    input logic        rd,
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rdw,
    input int          gd,
    input int          rdl
  );
    logic        e_f;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        f_seen;
    logic [31:0] rd_seen;
    int          gcyc;
    int          rcyc;
    int          nreq;
    int          rspc;
    int          e_rspc;
    model(rd, wr, f3, a, wd, rdw, e_f, e_be, e_wd, e_rd);
    @(negedge clk);
    chk("ready_pre", 32'(ex_bus.req_ready), 32'd1);
    ex_bus.req_valid = 1'b1;
    ex_bus.MemRead   = rd;
    ex_bus.MemWrite  = wr;
    ex_bus.Funct3    = f3;
    ex_bus.ALUResult = a;
    ex_bus.WrData    = wd;
    @(negedge clk);
    idle_bus();
    ex_bus.Funct3    = 3'($urandom);
    ex_bus.ALUResult = $urandom;
    ex_bus.WrData    = $urandom;
    if (!rd && !wr) begin
      repeat (3) begin
        chk("noop_rsp", 32'(ex_bus.rsp_valid), 32'd0);
        chk("noop_req", 32'(mem_bus.mem_req), 32'd0);
        @(negedge clk);
      end
      chk("noop_ready", 32'(ex_bus.req_ready), 32'd1);
      return;
    end
    gcyc    = 1 + gd;
    rcyc    = gcyc + 1 + rdl;
    nreq    = 0;
    rspc    = -1;
    f_seen  = 1'b0;
    rd_seen = '0;
    for (int c = 1; c <= 60 && rspc < 0; c++) begin
      if (ex_bus.rsp_valid) begin
        rspc    = c;
        f_seen  = ex_bus.fault;
        rd_seen = ex_bus.RdData;
      end
      if (mem_bus.mem_req) nreq++;
      if (!e_f && c == gcyc) begin
        chk("addr", mem_bus.mem_addr, {a[31:2], 2'b00});
        chk("we", 32'(mem_bus.mem_we), 32'(wr));
        if (wr) begin
          chk("be", 32'(mem_bus.mem_be), 32'(e_be));
          chk("wdata", mem_bus.mem_wdata, e_wd);
        end
      end
      mem_bus.mem_gnt    = !e_f && c == gcyc;
      mem_bus.mem_rvalid = (!e_f && rd && c == rcyc) ||
                           ((e_f || c <= gcyc) && ($urandom % 2 == 1));
      mem_bus.mem_rdata  = (c == rcyc) ? rdw : $urandom;
      @(negedge clk);
    end
    idle_bus();
    e_rspc = e_f ? 1 : wr ? gcyc + 1 : rcyc + 1;
    chk("rsp_cyc", rspc, e_rspc);
    chk("req_cycles", nreq, e_f ? 0 : gcyc);
    chk("fault", 32'(f_seen), 32'(e_f));
    chk("rdata", rd_seen, e_rd);
    chk("rsp_pulse", 32'(ex_bus.rsp_valid), 32'd0);
    chk("rd_hold", ex_bus.RdData, e_rd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_bus();
    ex_bus.Funct3      = '0;
    ex_bus.ALUResult   = '0;
    ex_bus.WrData      = '0;
    mem_bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ex_bus.req_ready), 32'd1);
    chk("rst_rsp", 32'(ex_bus.rsp_valid), 32'd0);
    chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_rd", ex_bus.RdData, 32'd0);
    reset = 1'b1;

    do_op(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 2, 0);
    do_op(0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 0, 0);
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, 0);
    chk("LB_val", ex_bus.RdData, 32'hFFFF_FF80);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 1, 1);
    chk("LBU_val", ex_bus.RdData, 32'h0000_0080);
    do_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 0, 2);
    chk("LH_val", ex_bus.RdData, 32'hFFFF_8001);
    do_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 2, 0);
    chk("LHU_val", ex_bus.RdData, 32'h0000_8001);
    do_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
    chk("LWmis_rd", ex_bus.RdData, 32'd0);
    do_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    do_op(1, 1, 3'b010, 32'h100, 32'h5, 32'h0, 0, 0);
    do_op(0, 0, 3'b010, 32'h100, 32'h5, 32'h0, 0, 0);

    // reset while a granted LW waits for read data
    @(negedge clk);
    ex_bus.req_valid = 1'b1;
    ex_bus.MemRead   = 1'b1;
    ex_bus.Funct3    = 3'b010;
    ex_bus.ALUResult = 32'h200;
    @(negedge clk);
    idle_bus();
    chk("rw_req", 32'(mem_bus.mem_req), 32'd1);
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    chk("rw_wait", 32'(ex_bus.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rw_rst_ready", 32'(ex_bus.req_ready), 32'd1);
    chk("rw_rst_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    repeat (2) begin
      chk("rw_rsp", 32'(ex_bus.rsp_valid), 32'd0);
      chk("rw_rd", ex_bus.RdData, 32'd0);
      chk("rw_ready", 32'(ex_bus.req_ready), 32'd1);
      @(negedge clk);
    end

    for (int i = 0; i < 80; i++) begin
      int          k;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      k  = int'($urandom % 10);
      rd = (k == 0) || (k >= 2 && k < 6);
      wr = (k == 0) || (k >= 6);
      a  = {$urandom_range(0, 255), 2'($urandom)};
      do_op(rd, wr, 3'($urandom), a, $urandom, $urandom,
            int'($urandom % 4), int'($urandom % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
